// File: rtl/axis_hdr_pkg.sv
// Shared types and keep-mask helpers for the header insert/strip stages.
// Byte 0 of every beat sits in the most significant lane; keep[MSB] flags byte 0.
package axis_hdr_pkg;

  typedef enum logic [1:0] {IDLE, FIRST, BODY, FLUSH} state_e;

  localparam int BYTE_W     = 8;
  localparam int KEEP_MAX_W = 64;

  function automatic int keep_count(input logic [KEEP_MAX_W-1:0] keep);
    int c;
    c = 0;
    for (int i = 0; i < KEEP_MAX_W; i++) c += int'(keep[i]);
    return c;
  endfunction

  // Top n bits of a w-bit field set; result is right-aligned in KEEP_MAX_W bits.
  function automatic logic [KEEP_MAX_W-1:0] keep_from_count(input int n, input int w);
    logic [KEEP_MAX_W-1:0] m;
    m = '0;
    for (int i = 0; i < KEEP_MAX_W; i++) begin
      if (i < w && i + n >= w) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/axis_byte_realign.sv
// Combinational merge of the residual bytes with the current beat for a header
// of S bytes, plus the keep masks needed by the strip FSM.
module axis_byte_realign
  import axis_hdr_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD) + 1
) (
  input  logic [DATA_WD-1:0]      i_res,
  input  logic [BYTE_CNT_WD-1:0]  i_res_cnt,
  input  logic [DATA_WD-1:0]      i_data,
  input  logic [DATA_BYTE_WD-1:0] i_keep,
  input  logic [BYTE_CNT_WD-1:0]  i_s,
  output logic [DATA_WD-1:0]      o_merge_data,
  output logic [DATA_BYTE_WD-1:0] o_merge_keep,
  output logic                    o_ends_here,
  output logic                    o_short,
  output logic [DATA_WD-1:0]      o_next_res,
  output logic [BYTE_CNT_WD-1:0]  o_next_cnt,
  output logic [DATA_BYTE_WD-1:0] o_hdr_keep,
  output logic [DATA_BYTE_WD-1:0] o_flush_keep
);

  int w_n;
  int w_s;
  int w_r;
  int w_hk_n;
  logic [KEEP_MAX_W-1:0] w_mk;
  logic [KEEP_MAX_W-1:0] w_hk;
  logic [KEEP_MAX_W-1:0] w_fk;

  always_comb begin
    w_n         = keep_count(KEEP_MAX_W'(i_keep));
    w_s         = int'(i_s);
    w_r         = int'(i_res_cnt);
    w_hk_n      = (w_s < w_n) ? w_s : w_n;
    o_ends_here = (w_n <= w_s);
    o_short     = (w_n < w_s);
    w_hk        = keep_from_count(w_hk_n, DATA_BYTE_WD);
    w_fk        = keep_from_count(w_r, DATA_BYTE_WD);
    w_mk        = keep_from_count(o_ends_here ? DATA_BYTE_WD - w_s + w_n : DATA_BYTE_WD,
                                  DATA_BYTE_WD);
    // Bytes past the header move up to lane 0; they become the next beat's head.
    o_next_res  = i_data << (w_s * BYTE_W);
    o_next_cnt  = BYTE_CNT_WD'((w_n > w_s) ? w_n - w_s : 0);
    if (w_s == 0) begin
      o_merge_data = i_data;
      o_merge_keep = i_keep;
    end else begin
      o_merge_data = i_res | (i_data >> ((DATA_BYTE_WD - w_s) * BYTE_W));
      o_merge_keep = w_mk[DATA_BYTE_WD-1:0];
    end
    o_hdr_keep   = w_hk[DATA_BYTE_WD-1:0];
    o_flush_keep = w_fk[DATA_BYTE_WD-1:0];
  end

endmodule

// File: rtl/axi_stream_strip_header.sv
// Strips a 0..DATA_BYTE_WD byte header from each AXI-Stream packet, returns the
// first beat on a one-beat header channel and re-aligns the payload to lane 0.
module axi_stream_strip_header
  import axis_hdr_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  input  logic                    valid_len,
  output logic                    ready_len,
  input  logic [BYTE_CNT_WD-1:0]  hdr_len,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  output logic                    valid_hdr,
  input  logic                    ready_hdr,
  output logic [DATA_WD-1:0]      data_hdr,
  output logic [DATA_BYTE_WD-1:0] keep_hdr,
  output logic                    hdr_short
);

  localparam logic [BYTE_CNT_WD-1:0] MAX_S = BYTE_CNT_WD'(DATA_BYTE_WD);

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic                    r_live;
  logic [BYTE_CNT_WD-1:0]  r_s;
  logic [BYTE_CNT_WD-1:0]  r_res_cnt;
  logic [DATA_WD-1:0]      r_res;
  logic                    r_valid_out;
  logic [DATA_WD-1:0]      r_data_out;
  logic [DATA_BYTE_WD-1:0] r_keep_out;
  logic                    r_last_out;
  logic                    r_valid_hdr;
  logic [DATA_WD-1:0]      r_data_hdr;
  logic [DATA_BYTE_WD-1:0] r_keep_hdr;
  logic                    r_hdr_short;

  logic                    w_slot_free;
  logic                    w_rdy_in;
  logic                    w_rdy_len;
  logic                    w_len_acc;
  logic                    w_hdr_ld;
  logic                    w_res_ld;
  logic                    w_pay_ld;
  logic [DATA_WD-1:0]      w_pay_data;
  logic [DATA_BYTE_WD-1:0] w_pay_keep;
  logic                    w_pay_last;
  logic [DATA_WD-1:0]      w_merge_data;
  logic [DATA_BYTE_WD-1:0] w_merge_keep;
  logic                    w_ends_here;
  logic                    w_short;
  logic [DATA_WD-1:0]      w_next_res;
  logic [BYTE_CNT_WD-1:0]  w_next_cnt;
  logic [DATA_BYTE_WD-1:0] w_hdr_keep;
  logic [DATA_BYTE_WD-1:0] w_flush_keep;

  axis_byte_realign #(
    .DATA_WD      (DATA_WD),
    .DATA_BYTE_WD (DATA_BYTE_WD),
    .BYTE_CNT_WD  (BYTE_CNT_WD)
  ) u_realign (
    .i_res        (r_res),
    .i_res_cnt    (r_res_cnt),
    .i_data       (data_in),
    .i_keep       (keep_in),
    .i_s          (r_s),
    .o_merge_data (w_merge_data),
    .o_merge_keep (w_merge_keep),
    .o_ends_here  (w_ends_here),
    .o_short      (w_short),
    .o_next_res   (w_next_res),
    .o_next_cnt   (w_next_cnt),
    .o_hdr_keep   (w_hdr_keep),
    .o_flush_keep (w_flush_keep)
  );

  assign w_slot_free = !r_valid_out || ready_out;

  always_comb begin
    w_state_nxt = r_state;
    w_rdy_len   = 1'b0;
    w_rdy_in    = 1'b0;
    w_len_acc   = 1'b0;
    w_hdr_ld    = 1'b0;
    w_res_ld    = 1'b0;
    w_pay_ld    = 1'b0;
    w_pay_data  = '0;
    w_pay_keep  = '0;
    w_pay_last  = 1'b0;
    case (r_state)
      IDLE: begin
        w_rdy_len = r_live;
        if (valid_len && w_rdy_len) begin
          w_len_acc   = 1'b1;
          w_state_nxt = FIRST;
        end
      end
      FIRST: begin
        // A new header cannot start until the previous one has been taken.
        w_rdy_in = !r_valid_hdr && w_slot_free;
        if (valid_in && w_rdy_in) begin
          w_hdr_ld = 1'b1;
          w_res_ld = 1'b1;
          if (r_s == '0) begin
            w_pay_ld    = 1'b1;
            w_pay_data  = data_in;
            w_pay_keep  = keep_in;
            w_pay_last  = last_in;
            w_state_nxt = last_in ? IDLE : BODY;
          end else if (last_in) begin
            w_state_nxt = (w_next_cnt == '0) ? IDLE : FLUSH;
          end else begin
            w_state_nxt = BODY;
          end
        end
      end
      BODY: begin
        w_rdy_in = w_slot_free;
        if (valid_in && w_rdy_in) begin
          w_res_ld   = 1'b1;
          w_pay_ld   = 1'b1;
          w_pay_data = w_merge_data;
          w_pay_keep = w_merge_keep;
          w_pay_last = last_in && (r_s == '0 || w_ends_here);
          if (last_in) w_state_nxt = w_pay_last ? IDLE : FLUSH;
        end
      end
      FLUSH: begin
        if (w_slot_free) begin
          w_pay_ld    = 1'b1;
          w_pay_data  = r_res;
          w_pay_keep  = w_flush_keep;
          w_pay_last  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Output slots load on a new beat, otherwise hold until the consumer takes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live      <= 1'b0;
      r_s         <= '0;
      r_res       <= '0;
      r_res_cnt   <= '0;
      r_valid_out <= 1'b0;
      r_data_out  <= '0;
      r_keep_out  <= '0;
      r_last_out  <= 1'b0;
      r_valid_hdr <= 1'b0;
      r_data_hdr  <= '0;
      r_keep_hdr  <= '0;
      r_hdr_short <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_len_acc) r_s <= (hdr_len > MAX_S) ? MAX_S : hdr_len;
      if (w_res_ld) begin
        r_res     <= w_next_res;
        r_res_cnt <= w_next_cnt;
      end
      if (w_pay_ld) begin
        r_valid_out <= 1'b1;
        r_data_out  <= w_pay_data;
        r_keep_out  <= w_pay_keep;
        r_last_out  <= w_pay_last;
      end else if (ready_out) begin
        r_valid_out <= 1'b0;
      end
      if (w_hdr_ld) begin
        r_valid_hdr <= 1'b1;
        r_data_hdr  <= data_in;
        r_keep_hdr  <= w_hdr_keep;
        r_hdr_short <= w_short;
      end else if (ready_hdr) begin
        r_valid_hdr <= 1'b0;
      end
    end
  end

  assign ready_in  = w_rdy_in;
  assign ready_len = w_rdy_len;
  assign valid_out = r_valid_out;
  assign data_out  = r_data_out;
  assign keep_out  = r_keep_out;
  assign last_out  = r_last_out;
  assign valid_hdr = r_valid_hdr;
  assign data_hdr  = r_data_hdr;
  assign keep_hdr  = r_keep_hdr;
  assign hdr_short = r_hdr_short;

endmodule

// File: doc/axi_stream_strip_header.md
Name: axi_stream_strip_header

Overview:
- Receive-side counterpart of the header-insert stage; sits directly downstream of it on the loopback/receive path.
- Removes a per-packet header of 0..DATA_BYTE_WD bytes from the front of an AXI-Stream packet.
- Presents the header on a separate one-beat channel.
- Re-aligns the remaining payload so its first byte lands in byte lane 0 of beat 0.

Parameters:
- DATA_WD, 32, stream data width in bits (multiple of 8).
- DATA_BYTE_WD, DATA_WD/8, byte lanes per beat.
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD)+1, width of header length (must encode DATA_BYTE_WD).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- valid_in/ready_in  in/out  1/1  input stream handshake
- data_in  in  DATA_WD  byte 0 = data_in[DATA_WD-1 -: 8] (MSB first)
- keep_in  in  DATA_BYTE_WD  keep_in[DATA_BYTE_WD-1] = byte 0; all-ones except on last beat, where it is contiguous from the MSB
- last_in  in  1  last beat of packet
- valid_len/ready_len  in/out  1/1  per-packet header-length handshake
- hdr_len  in  BYTE_CNT_WD  header bytes S, 0..DATA_BYTE_WD; values above DATA_BYTE_WD are clamped to DATA_BYTE_WD
- valid_out/ready_out  out/in  1/1  payload stream handshake
- data_out  out  DATA_WD  realigned payload
- keep_out  out  DATA_BYTE_WD  same keep convention as input
- last_out  out  1  last payload beat
- valid_hdr/ready_hdr  out/in  1/1  header channel handshake
- data_hdr  out  DATA_WD  first beat of packet, unmodified
- keep_hdr  out  DATA_BYTE_WD  header bytes present (MSB-contiguous)
- hdr_short  out  1  qualified by valid_hdr; packet held fewer than S bytes

Behaviour:
- Reset: all valid/ready outputs 0; data_out, keep_out, last_out, data_hdr, keep_hdr, hdr_short, residual register and counters 0; FSM = IDLE.
- All outputs are registered. A payload beat appears 1 cycle after the input beat that completes it.
- Output registers hold value while valid && !ready (AXI stability rule).
- IDLE:
  - ready_len = 1, ready_in = 0.
  - On valid_len: latch S, go to FIRST.
- FIRST:
  - ready_in = !valid_hdr && (payload slot free or being drained this cycle).
  - On the accepted beat with n valid bytes:
    - Load data_hdr = data_in.
    - keep_hdr = top min(S,n) keep bits set.
    - hdr_short = (n < S).
    - valid_hdr <= 1.
  - Bytes S..n-1 go to the residual register (R = n-S bytes; R = 0 if n <= S).
  - If S == 0: the beat also goes to the payload slot directly (pass-through mode for the whole packet).
  - If last_in and R == 0: no payload emitted, go to IDLE.
  - If last_in and R > 0: go to FLUSH.
  - Else: go to BODY.
- BODY:
  - ready_in = payload slot free or draining.
  - Each accepted beat outputs {residual (DATA_BYTE_WD-S bytes), first S bytes of data_in}.
  - The residual then takes the remaining DATA_BYTE_WD-S bytes.
  - On last_in with n bytes:
    - If n <= S: this output beat is final, keep = (DATA_BYTE_WD-S)+n ones, last_out = 1, go to IDLE.
    - Else: go to FLUSH.
  - S == DATA_BYTE_WD: residual is empty, beats pass straight through.
- FLUSH:
  - ready_in = 0.
  - Emit residual as one beat: keep = top (n-S) bits (or R bits if from FIRST), last_out = 1.
  - Go to IDLE when the beat is accepted into the slot.
- Header channel is independent of payload. The next packet's FIRST stalls until the previous header is consumed.
- Pass-through mode (S == 0): data_hdr = first beat, keep_hdr = 0, and the payload is identical to the input.
- Simultaneous valid_len in a non-IDLE state is ignored (ready_len = 0).
- Reset mid-packet discards all state; the next accepted beat after reset must be a packet start.

Decomposition:
- Shared package axis_hdr_pkg:
  - FSM state enum {IDLE, FIRST, BODY, FLUSH}.
  - Function keep_count(keep) -> number of set bits.
  - Function keep_from_count(n) -> MSB-contiguous mask.
  - Byte-lane ordering constants shared with the insert stage.
- One sub-module: axis_byte_realign (combinational merge of residual + current beat for a given S, plus the keep generation).

Test Plan:
- S=2, 3 beats 0xAABBCCDD / 0x11223344 / 0x5566_xxxx keep 1100 -> hdr data 0xAABBCCDD keep 1100; payload 0xCCDD1122 keep 1111, then 0x33445566 keep 1111 last.
- S=1, 2 beats 0x01020304 / 0x05060708 keep 1110 -> payload 0x02030405 keep 1111, then 0x0607xxxx keep 1100 last (FLUSH path).
- S=0, 2 beats -> payload bit-identical to input, keep_hdr=0000, 1-cycle latency.
- S=4, single beat keep 1111 last -> header only, keep_hdr 1111; no valid_out pulse.
- S=3, single beat keep 1100 last -> hdr keep 1100, hdr_short=1; no payload.
- ready_out/ready_hdr randomly low 50% over 20 packets, plus rst_n pulsed mid-BODY -> no data loss or reorder, outputs stable under stall, all outputs 0 after reset, next packet correct.
